// File: rtl/pwm_fade_seq_pkg.sv
// Shared types for the LED fade sequencer: FSM state encoding and colour-mix table.
// Pure declarations, no timing or flow control.
package pwm_fade_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RISE    = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_FALL    = 3'd3,
    ST_HOLD_LO = 3'd4
  } state_t;

  localparam logic [2:0] COLOUR_LAST = 3'd6;

  // Returns {b,g,r} channel enables for a colour index.
  function automatic logic [2:0] colour_mask(input logic [2:0] colour);
    logic [2:0] mask;
    mask = 3'b000;
    case (colour)
      3'd0: mask = 3'b001;
      3'd1: mask = 3'b010;
      3'd2: mask = 3'b100;
      3'd3: mask = 3'b011;
      3'd4: mask = 3'b110;
      3'd5: mask = 3'b101;
      3'd6: mask = 3'b111;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/pwm_fade_seq_frame_timer.sv
// Frame counter mirroring the pwm counters plus a frames-per-step prescaler.
// frame_end/step_tick are combinational from registered counts; no backpressure.
module pwm_frame_timer #(
  parameter int WIDTH = 16,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [WIDTH-1:0] max,
  input  logic [DIV_W-1:0] frames_per_step,
  output logic             frame_end,
  output logic             step_tick
);

  logic [WIDTH-1:0] frame_cnt;
  logic [DIV_W-1:0] step_cnt;
  logic [DIV_W-1:0] fps_eff;
  logic [DIV_W:0]   step_cnt_inc;

  assign fps_eff      = (frames_per_step == '0) ? DIV_W'(1) : frames_per_step;
  assign step_cnt_inc = {1'b0, step_cnt} + (DIV_W+1)'(1);
  assign frame_end    = (frame_cnt >= max);
  assign step_tick    = frame_end && (step_cnt_inc >= {1'b0, fps_eff});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
    end else if (frame_end) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + WIDTH'(1);
    end
  end

  // Prescaler is held clear while the sequencer is disabled; frame_cnt keeps running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_cnt <= '0;
    end else if (clr || step_tick) begin
      step_cnt <= '0;
    end else if (frame_end) begin
      step_cnt <= step_cnt_inc[DIV_W-1:0];
    end
  end

endmodule

// File: rtl/pwm_fade_seq.sv
// RGB fade sequencer: ramp/hold/ramp/hold per colour mix; thresholds load one cycle after frame_end.
// Free-running, no backpressure; enable low forces IDLE on the next clock.
module pwm_fade_seq
  import pwm_fade_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] max,
  input  logic [WIDTH-1:0] step,
  input  logic [DIV_W-1:0] frames_per_step,
  input  logic [DIV_W-1:0] hold_steps,
  output logic [WIDTH-1:0] threshold_r,
  output logic [WIDTH-1:0] threshold_g,
  output logic [WIDTH-1:0] threshold_b,
  output logic [WIDTH-1:0] level,
  output logic [2:0]       colour,
  output logic             cycle_done
);

  logic frame_end;
  logic step_tick;

  pwm_frame_timer #(.WIDTH(WIDTH), .DIV_W(DIV_W)) u_timer (
    .clk             (clk),
    .reset           (reset),
    .clr             (!enable),
    .max             (max),
    .frames_per_step (frames_per_step),
    .frame_end       (frame_end),
    .step_tick       (step_tick)
  );

  state_t           state, state_nxt;
  logic [WIDTH-1:0] level_nxt;
  logic [DIV_W-1:0] hold_cnt, hold_nxt;
  logic [2:0]       colour_nxt;
  logic             cycle_done_nxt;
  logic [WIDTH-1:0] step_eff;
  logic [WIDTH:0]   rise_sum;

  assign step_eff = (step == '0) ? WIDTH'(1) : step;
  assign rise_sum = {1'b0, level} + {1'b0, step_eff};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      level      <= '0;
      hold_cnt   <= '0;
      colour     <= '0;
      cycle_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      level      <= level_nxt;
      hold_cnt   <= hold_nxt;
      colour     <= colour_nxt;
      cycle_done <= cycle_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    level_nxt      = level;
    hold_nxt       = hold_cnt;
    colour_nxt     = colour;
    cycle_done_nxt = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
      level_nxt = '0;
      hold_nxt  = '0;
    end else if (step_tick) begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_RISE;
          level_nxt = '0;
        end
        ST_RISE: begin
          // Wide compare so a ramp near the top of the range cannot wrap.
          if (rise_sum >= {1'b0, max}) begin
            level_nxt = max;
            hold_nxt  = '0;
            state_nxt = ST_HOLD_HI;
          end else begin
            level_nxt = rise_sum[WIDTH-1:0];
          end
        end
        ST_HOLD_HI: begin
          if (hold_cnt >= hold_steps) state_nxt = ST_FALL;
          else                        hold_nxt  = hold_cnt + DIV_W'(1);
        end
        ST_FALL: begin
          if (level <= step_eff) begin
            level_nxt = '0;
            hold_nxt  = '0;
            state_nxt = ST_HOLD_LO;
          end else begin
            level_nxt = level - step_eff;
          end
        end
        ST_HOLD_LO: begin
          if (hold_cnt >= hold_steps) begin
            colour_nxt     = (colour == COLOUR_LAST) ? 3'd0 : colour + 3'd1;
            cycle_done_nxt = 1'b1;
            state_nxt      = ST_RISE;
          end else begin
            hold_nxt = hold_cnt + DIV_W'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  logic [2:0][WIDTH-1:0] thr_q, thr_nxt;
  logic [WIDTH-1:0]      level_clamp;
  logic [2:0]            mask;

  // Clamp guards against max being lowered below the current level mid-ramp.
  always_comb begin
    level_clamp = (level > max) ? max : level;
    mask        = colour_mask(colour);
    thr_nxt     = thr_q;
    for (int i = 0; i < 3; i++) begin
      thr_nxt[i] = (state == ST_IDLE || !mask[i]) ? max : (max - level_clamp);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thr_q <= '1;
    end else if (frame_end) begin
      thr_q <= thr_nxt;
    end
  end

  assign threshold_r = thr_q[0];
  assign threshold_g = thr_q[1];
  assign threshold_b = thr_q[2];

endmodule

// File: tb/tb_pwm_fade_seq.sv
// Scoreboarded bench for pwm_fade_seq: directed scenarios then randomized configs.
module tb_pwm_fade_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] max = 16'd0;
  logic [15:0] step = 16'd0;
  logic [7:0]  fps = 8'd0;
  logic [7:0]  hold = 8'd0;
  logic [15:0] threshold_r, threshold_g, threshold_b, level;
  logic [2:0]  colour;
  logic        cycle_done;

  pwm_fade_seq #(.WIDTH(16), .DIV_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .max             (max),
    .step            (step),
    .frames_per_step (fps),
    .hold_steps      (hold),
    .threshold_r     (threshold_r),
    .threshold_g     (threshold_g),
    .threshold_b     (threshold_b),
    .level           (level),
    .colour          (colour),
    .cycle_done      (cycle_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int thr[3];
    int lvl;
    int col;
    int cd;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phases of the fade, kept as plain integers.
  localparam int P_IDLE = 0, P_UP = 1, P_TOP = 2, P_DOWN = 3, P_BOTTOM = 4;
  int lit[7] = '{1, 2, 4, 3, 6, 5, 7};
  int m_pos, m_frames, m_ph, m_lvl, m_hc, m_col, m_cd, m_adv;
  int m_th[3];

  task automatic model_reset();
    m_pos = 0; m_frames = 0; m_ph = P_IDLE; m_lvl = 0; m_hc = 0;
    m_col = 0; m_cd = 0;
    for (int i = 0; i < 3; i++) m_th[i] = 'hFFFF;
  endtask

  task automatic model_clock();
    int mx, st, per, lv;
    bit fe, tk;
    mx  = int'(max);
    st  = (step == 0) ? 1 : int'(step);
    per = (fps == 0) ? 1 : int'(fps);
    fe  = (m_pos >= mx);
    tk  = fe && (m_frames + 1 >= per);
    if (fe) begin
      lv = (m_lvl < mx) ? m_lvl : mx;
      for (int i = 0; i < 3; i++)
        m_th[i] = (m_ph == P_IDLE || ((lit[m_col] >> i) & 1) == 0) ? mx : mx - lv;
    end
    m_pos = fe ? 0 : m_pos + 1;
    m_cd = 0;
    if (!enable) begin
      m_frames = 0; m_ph = P_IDLE; m_lvl = 0; m_hc = 0;
    end else begin
      if (fe) m_frames = tk ? 0 : m_frames + 1;
      if (tk) begin
        if (m_ph == P_IDLE) begin
          m_ph = P_UP; m_lvl = 0;
        end else if (m_ph == P_UP) begin
          if (m_lvl + st >= mx) begin m_lvl = mx; m_hc = 0; m_ph = P_TOP; end
          else m_lvl = m_lvl + st;
        end else if (m_ph == P_TOP) begin
          if (m_hc >= int'(hold)) m_ph = P_DOWN; else m_hc++;
        end else if (m_ph == P_DOWN) begin
          if (m_lvl <= st) begin m_lvl = 0; m_hc = 0; m_ph = P_BOTTOM; end
          else m_lvl = m_lvl - st;
        end else begin
          if (m_hc >= int'(hold)) begin
            m_col = (m_col + 1) % 7; m_cd = 1; m_adv++; m_ph = P_UP;
          end else m_hc++;
        end
      end
    end
  endtask

  initial begin
    m_adv = 0;
    model_reset();
  end

  always @(posedge clk) begin
    exp_t e;
    if (!reset) model_reset();
    else model_clock();
    for (int i = 0; i < 3; i++) e.thr[i] = m_th[i];
    e.lvl = m_lvl; e.col = m_col; e.cd = m_cd;
    sb_q.push_back(e);
  end

  // Monitor: compares every presented cycle against the scoreboard.
  int cd_pulses = 0;
  int lvl_prev = 0;
  int col_prev = 0;
  int lvl_seen[$];
  int col_seen[$];

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("threshold_r", threshold_r, e.thr[0]);
      chk("threshold_g", threshold_g, e.thr[1]);
      chk("threshold_b", threshold_b, e.thr[2]);
      chk("level", level, e.lvl);
      chk("colour", colour, e.col);
      chk("cycle_done", cycle_done, e.cd);
    end
    if (cycle_done === 1'b1) cd_pulses++;
    if (int'(level) != lvl_prev) begin lvl_seen.push_back(int'(level)); lvl_prev = int'(level); end
    if (int'(colour) != col_prev) begin col_seen.push_back(int'(colour)); col_prev = int'(colour); end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired, got timeout expected event", nm);
  endtask

  initial begin
    int budget, base_adv, base_pulses, c0;
    int exp_lvls[6] = '{3, 6, 9, 6, 3, 0};

    // Scenario 1: reset, disabled, max=9.
    max = 16'd9; step = 16'd3; fps = 8'd1; hold = 8'd0;
    cyc(3);
    reset = 1'b1;
    cyc(30);

    // Scenario 2: one full colour cycle on red.
    lvl_seen.delete();
    enable = 1'b1;
    budget = 0;
    while (m_adv < 1 && budget < 1000) begin cyc(1); budget++; end
    if (m_adv < 1) timeout("first_cycle");
    cyc(3);
    chk("ramp_points", lvl_seen.size(), 6);
    for (int i = 0; i < 6 && i < lvl_seen.size(); i++) chk("ramp_level", lvl_seen[i], exp_lvls[i]);
    chk("pulse_count_1", cd_pulses, 1);

    // Scenario 3: seven more advances, colour walks and wraps.
    col_seen.delete();
    base_adv = m_adv; base_pulses = cd_pulses; c0 = int'(colour);
    budget = 0;
    while (m_adv < base_adv + 7 && budget < 8000) begin cyc(1); budget++; end
    if (m_adv < base_adv + 7) timeout("seven_cycles");
    cyc(3);
    chk("pulse_count_7", cd_pulses - base_pulses, 7);
    chk("colour_changes", col_seen.size(), 7);
    for (int i = 0; i < 7 && i < col_seen.size(); i++) chk("colour_seq", col_seen[i], (c0 + 1 + i) % 7);

    // Scenario 4: lower max mid-ramp at level 6.
    budget = 0;
    while (!(m_ph == P_UP && m_lvl == 6) && budget < 2000) begin cyc(1); budget++; end
    if (!(m_ph == P_UP && m_lvl == 6)) timeout("reach_level6");
    max = 16'd4;
    cyc(60);
    max = 16'd9;
    cyc(20);

    // Scenario 5: drop enable on a falling-ramp step tick, then re-enable.
    budget = 0;
    while (!(m_ph == P_DOWN && m_pos >= int'(max)) && budget < 2000) begin cyc(1); budget++; end
    if (!(m_ph == P_DOWN && m_pos >= int'(max))) timeout("reach_fall");
    c0 = m_col;
    enable = 1'b0;
    cyc(25);
    enable = 1'b1;
    cyc(60);
    chk("colour_kept", colour, c0);

    // Scenario 6: degenerate zeros.
    max = 16'd0; step = 16'd0; fps = 8'd0; hold = 8'd0;
    cyc(40);

    // Randomized configurations with occasional reset and enable drops.
    for (int s = 0; s < 15; s++) begin
      max    = 16'($urandom_range(0, 40));
      step   = 16'($urandom_range(0, 12));
      fps    = 8'($urandom_range(0, 3));
      hold   = 8'($urandom_range(0, 3));
      enable = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 6) == 0) begin
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
      end
      if (s == 7) max = 16'hFFFE;
      cyc($urandom_range(50, 300));
    end

    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
